// File: rtl/regfile_rw.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one synchronous write port and a handshaked dump engine that streams r0..r31.

module regfile_rd_port #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int IW       = $clog2(NUM_REGS)
) (
  input  logic                             rst,
  input  logic                             re,
  input  logic [IW-1:0]                    raddr,
  input  logic                             we,
  input  logic [IW-1:0]                    waddr,
  input  logic [DATA_W-1:0]                wdata,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  output logic [DATA_W-1:0]                rdata
);
  always_comb begin
    rdata = '0;
    if (rst || !re || raddr == '0) rdata = '0;
    else if (we && waddr == raddr)  rdata = wdata;
    else                            rdata = regs[raddr];
  end
endmodule

module regfile_rw #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int IW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [IW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [IW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IW-1:0]     dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);
  localparam int NUM_PORTS = 3;
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} dump_state_e;

  logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
  logic [NUM_PORTS-1:0]             re_v;
  logic [NUM_PORTS-1:0][IW-1:0]     raddr_v;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_v;
  logic [IW-1:0]                    nxt_idx;
  dump_state_e                      state;

  always_ff @(posedge clk) begin
    if (rst)                         regs <= '0;
    else if (we && waddr != '0)      regs[waddr] <= wdata;
  end

  // Port 2 is the dump engine's own snapshot lane, so the next beat sees
  // the same write-through bypass as the ID-stage ports.
  assign nxt_idx = dump_idx + 1'b1;
  assign re_v    = {1'b1, re2, re1};
  assign raddr_v = {nxt_idx, raddr2, raddr1};
  assign rdata1  = rdata_v[0];
  assign rdata2  = rdata_v[1];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    regfile_rd_port #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .IW(IW)) u_rd (
      .rst   (rst),
      .re    (re_v[p]),
      .raddr (raddr_v[p]),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .regs  (regs),
      .rdata (rdata_v[p])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (dump_start) begin
          state      <= STREAM;
          dump_valid <= 1'b1;
          dump_busy  <= 1'b1;
          dump_idx   <= '0;
          dump_data  <= '0;
        end
        // Stalled beats hold idx/data; later writes are not reflected.
        STREAM: if (dump_ready) begin
          if (dump_idx == LAST) begin
            state      <= DONE;
            dump_valid <= 1'b0;
            dump_done  <= 1'b1;
          end else begin
            dump_idx  <= nxt_idx;
            dump_data <= rdata_v[2];
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_done <= 1'b0;
          dump_busy <= 1'b0;
          dump_idx  <= '0;
          dump_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_rw.sv
// Randomized bench for regfile_rw against an array-based register model
// and a beat-by-beat model of the dump stream.

module tb_regfile_rw;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re1 = 1'b0, re2 = 1'b0;
  logic [4:0]  raddr1 = '0, raddr2 = '0;
  logic [31:0] rdata1, rdata2;
  logic        dump_start = 1'b0, dump_ready = 1'b0;
  logic        dump_valid, dump_busy, dump_done;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  logic [31:0] mdl [32];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_rw dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy),
    .dump_done(dump_done)
  );

  // Advance one clock edge and apply that edge's effect to the model.
  task automatic step();
    @(posedge clk);
    if (rst) for (int i = 0; i < 32; i++) mdl[i] = '0;
    else if (we && waddr != 0) mdl[waddr] = wdata;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dump_start = 1'b1; dump_ready = 1'b1;
    step(); step();
    dump_start = 1'b0;
    n_cmp++;
    if ({dump_valid, dump_busy, dump_done} !== 3'b000 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_dump: valid=%b busy=%b done=%b idx=%0d data=%h, want all 0",
               dump_valid, dump_busy, dump_done, dump_idx, dump_data);
    end
    we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D; re1 = 1'b1; raddr1 = 5'd9;
    #1;
    n_cmp++;
    if (rdata1 !== 32'd0) begin
      n_err++; $display("FAIL reset_rd_gated: rdata1=%h want 0", rdata1);
    end
    step();
    rst = 1'b0; we = 1'b0; re1 = 1'b1; re2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      n_cmp++;
      if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
        n_err++; $display("FAIL reset_rd_all[%0d]: rdata1=%h rdata2=%h want 0", i, rdata1, rdata2);
      end
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; re1 = 1'b1; raddr1 = 5'd5;
    #1;
    n_cmp++;
    if (rdata1 !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL bypass_same: rdata1=%h want deadbeef", rdata1);
    end
    step();
    we = 1'b0; #1;
    n_cmp++;
    if (rdata1 !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL bypass_next: rdata1=%h want deadbeef", rdata1);
    end
  endtask

  task automatic test_r0();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; re2 = 1'b1; raddr2 = 5'd0;
    #1;
    n_cmp++;
    if (rdata2 !== 32'd0) begin
      n_err++; $display("FAIL r0_same: rdata2=%h want 0", rdata2);
    end
    step();
    we = 1'b0; #1;
    n_cmp++;
    if (rdata2 !== 32'd0) begin
      n_err++; $display("FAIL r0_next: rdata2=%h want 0", rdata2);
    end
  endtask

  task automatic test_random_rw();
    logic [31:0] e1, e2;
    for (int c = 0; c < 300; c++) begin
      we = 1'($urandom); waddr = 5'($urandom); wdata = $urandom;
      re1 = ($urandom_range(0, 7) != 0); re2 = ($urandom_range(0, 7) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom);
      #1;
      e1 = (!re1 || raddr1 == 0) ? 32'd0 : (we && waddr == raddr1) ? wdata : mdl[raddr1];
      e2 = (!re2 || raddr2 == 0) ? 32'd0 : (we && waddr == raddr2) ? wdata : mdl[raddr2];
      n_cmp++;
      if (rdata1 !== e1 || rdata2 !== e2) begin
        n_err++;
        $display("FAIL rand_rd[%0d]: rdata1=%h want %h, rdata2=%h want %h", c, rdata1, e1, rdata2, e2);
      end
      step();
    end
    we = 1'b0;
  endtask

  task automatic preload();
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i * 32'h11111111);
      step();
    end
    we = 1'b0;
  endtask

  task automatic test_dump_full();
    logic [31:0] exp;
    preload();
    dump_start = 1'b1; dump_ready = 1'b1;
    step();
    dump_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      exp = 32'(k * 32'h11111111);
      n_cmp++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_done !== 1'b0 ||
          dump_idx !== 5'(k) || dump_data !== exp) begin
        n_err++;
        $display("FAIL dump_beat[%0d]: valid=%b busy=%b done=%b idx=%0d data=%h, want 1 1 0 %0d %h",
                 k, dump_valid, dump_busy, dump_done, dump_idx, dump_data, k, exp);
      end
      step();
    end
    n_cmp++;
    if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_busy !== 1'b1) begin
      n_err++;
      $display("FAIL dump_done_n33: done=%b valid=%b busy=%b want 1 0 1", dump_done, dump_valid, dump_busy);
    end
    step();
    n_cmp++;
    if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
      n_err++; $display("FAIL dump_idle_after: done=%b busy=%b want 0 0", dump_done, dump_busy);
    end
  endtask

  task automatic test_dump_stall();
    int          exp_idx = 0;
    logic [31:0] exp_data = '0;
    bit          fin = 0, hit7 = 0;
    int          cyc = 0;
    dump_start = 1'b1; dump_ready = 1'b0;
    step();
    while (!fin && cyc < 400) begin
      n_cmp++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_done !== 1'b0 ||
          dump_idx !== 5'(exp_idx) || dump_data !== exp_data) begin
        n_err++;
        $display("FAIL stall_beat[cyc %0d]: valid=%b busy=%b done=%b idx=%0d data=%h, want 1 1 0 %0d %h",
                 cyc, dump_valid, dump_busy, dump_done, dump_idx, dump_data, exp_idx, exp_data);
      end
      dump_start = 1'($urandom);
      if (exp_idx == 7 && !hit7) begin
        hit7 = 1; dump_ready = 1'b0;
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
      end else begin
        dump_ready = cyc[0] ^ ($urandom_range(0, 3) == 0);
        we = 1'($urandom); waddr = 5'($urandom); wdata = $urandom;
      end
      step();
      if (dump_ready) begin
        if (exp_idx == 31) fin = 1;
        else begin exp_idx++; exp_data = mdl[exp_idx]; end
      end
      cyc++;
    end
    we = 1'b0; dump_start = 1'b0;
    n_cmp++;
    if (!fin || dump_done !== 1'b1 || dump_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_end: finished=%0d done=%b valid=%b want 1 1 0", fin, dump_done, dump_valid);
    end
    step();
    n_cmp++;
    if (dump_done !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
      n_err++;
      $display("FAIL stall_idle: done=%b busy=%b idx=%0d data=%h want 0 0 0 0",
               dump_done, dump_busy, dump_idx, dump_data);
    end
  endtask

  task automatic test_reset_mid_dump();
    preload();
    dump_start = 1'b1; dump_ready = 1'b1;
    step();
    dump_start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    n_cmp++;
    if (dump_idx !== 5'd10 || dump_valid !== 1'b1) begin
      n_err++; $display("FAIL rstmid_beat10: idx=%0d valid=%b want 10 1", dump_idx, dump_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0; re1 = 1'b1; raddr1 = 5'd3;
    #1;
    n_cmp++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0 || rdata1 !== 32'd0) begin
      n_err++;
      $display("FAIL rstmid_after: valid=%b busy=%b done=%b rdata1=%h want 0 0 0 0",
               dump_valid, dump_busy, dump_done, rdata1);
    end
    for (int k = 0; k < 30; k++) begin
      step();
      n_cmp++;
      if (dump_done !== 1'b0 || dump_valid !== 1'b0) begin
        n_err++; $display("FAIL rstmid_nodone[%0d]: done=%b valid=%b want 0 0", k, dump_done, dump_valid);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    #1;
    test_reset();
    test_bypass();
    test_r0();
    test_random_rw();
    test_dump_full();
    test_dump_stall();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
